tb_uart_loopback: RTL

// - Bench-side multi-channel UART echo, the successor to the hard-wired rxd=txd loopback.
// - Per channel: deserialise the DUT txd, buffer the bytes in a FIFO, then re-serialise them onto the DUT rxd.
// - Adds per-channel enable, TX hold, error flags and byte counters so the SoC UART can be tested under back-pressure.

---
 rtl/tb_uart_loopback_if.sv | 38 +++
 rtl/tb_uart_loopback.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tb_uart_loopback_if.sv
// Signal bundle between the SoC-side UART pins/controls and the bench-side
// multi-channel UART echo. The master drives serial data and controls; the
// slave (the echo) returns serial data, status flags and counters.
// Optional feature macro: TB_UART_LB_PARITY_EN adds the parity_err flag.
interface tb_uart_loopback_if #(
   parameter int NUM_CH = 1
);
   logic [NUM_CH-1:0]    uart_txd;
   logic [NUM_CH-1:0]    uart_rxd;
   logic [NUM_CH-1:0]    loop_en;
   logic [NUM_CH-1:0]    tx_hold;
   logic [NUM_CH-1:0]    frame_err;
   logic [NUM_CH-1:0]    overflow;
   logic [NUM_CH*16-1:0] byte_cnt;
`ifdef TB_UART_LB_PARITY_EN
   logic [NUM_CH-1:0]    parity_err;

   modport master (
      output uart_txd, loop_en, tx_hold,
      input  uart_rxd, frame_err, overflow, byte_cnt, parity_err
   );

   modport slave (
      input  uart_txd, loop_en, tx_hold,
      output uart_rxd, frame_err, overflow, byte_cnt, parity_err
   );
`else
   modport master (
      output uart_txd, loop_en, tx_hold,
      input  uart_rxd, frame_err, overflow, byte_cnt
   );

   modport slave (
      input  uart_txd, loop_en, tx_hold,
      output uart_rxd, frame_err, overflow, byte_cnt
   );
`endif
endinterface

// File: rtl/tb_uart_loopback.sv
// Multi-channel UART echo: each channel deserialises uart_txd, queues good
// bytes in a FIFO and re-serialises them onto uart_rxd. Per-channel enable,
// TX hold, sticky error flags and a saturating good-byte counter.
// Optional feature macro: TB_UART_LB_PARITY_EN (even parity after the data
// bits on both directions, plus a sticky parity_err flag).
module tb_uart_loopback #(
   parameter int NUM_CH       = 1,
   parameter int CLK_FREQ_MHZ = 50,
   parameter int BAUD_RATE    = 115200,
   parameter int FIFO_DEPTH   = 16
)(
   input logic               clk,
   input logic               rst,
   tb_uart_loopback_if.slave lb
);
   localparam int CLKS_PER_BIT = (CLK_FREQ_MHZ * 1000000) / BAUD_RATE;
   localparam int CNT_W        = $clog2(CLKS_PER_BIT + 1);
   localparam int AW           = $clog2(FIFO_DEPTH);
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

   typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP} rx_state_t;
   typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PAR, TX_STOP} tx_state_t;

   logic [NUM_CH-1:0]    rxd_vec;
   logic [NUM_CH-1:0]    frame_err_vec;
   logic [NUM_CH-1:0]    overflow_vec;
   logic [NUM_CH*16-1:0] byte_cnt_vec;

   assign lb.uart_rxd  = rxd_vec;
   assign lb.frame_err = frame_err_vec;
   assign lb.overflow  = overflow_vec;
   assign lb.byte_cnt  = byte_cnt_vec;
`ifdef TB_UART_LB_PARITY_EN
   logic [NUM_CH-1:0] par_err_vec;
   assign lb.parity_err = par_err_vec;
`endif

   genvar gi;
   generate
      for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
         logic             sync1_reg, sync2_reg, prev_reg;
         rx_state_t        rx_state_reg, rx_state_next;
         logic [CNT_W-1:0] rx_cnt_reg, rx_cnt_next;
         logic [2:0]       rx_idx_reg, rx_idx_next;
         logic [7:0]       rx_shift_reg, rx_shift_next;
         logic             rx_par_bad_reg, rx_par_bad_next;
         logic             rx_brk_reg, rx_brk_next;
         logic             frame_err_reg, frame_err_next;
         logic [15:0]      byte_cnt_reg, byte_cnt_next;
         logic             rx_push_req;
`ifdef TB_UART_LB_PARITY_EN
         logic             par_err_reg, par_err_next;
`endif
         logic [7:0]       fifo_mem [FIFO_DEPTH];
         logic [7:0]       rd_data_reg;
         logic [AW:0]      wr_ptr_reg, wr_ptr_next, rd_ptr_reg, rd_ptr_next;
         logic             empty_reg, empty_next;
         logic             overflow_reg, overflow_next;
         logic             fifo_full, push_ok;
         tx_state_t        tx_state_reg, tx_state_next;
         logic [CNT_W-1:0] tx_cnt_reg, tx_cnt_next;
         logic [2:0]       tx_idx_reg, tx_idx_next;
         logic             tx_line_reg, tx_line_next;
         logic             tx_pop;

         assign rxd_vec[gi]                = tx_line_reg;
         assign frame_err_vec[gi]          = frame_err_reg;
         assign overflow_vec[gi]           = overflow_reg;
         assign byte_cnt_vec[gi*16 +: 16]  = byte_cnt_reg;
`ifdef TB_UART_LB_PARITY_EN
         assign par_err_vec[gi]            = par_err_reg;
`endif

         // State registers: synchroniser, RX/TX FSMs, FIFO pointers and flags
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               sync1_reg      <= 1'b1;
               sync2_reg      <= 1'b1;
               prev_reg       <= 1'b1;
               rx_state_reg   <= RX_IDLE;
               rx_cnt_reg     <= '0;
               rx_idx_reg     <= '0;
               rx_shift_reg   <= '0;
               rx_par_bad_reg <= 1'b0;
               rx_brk_reg     <= 1'b0;
               frame_err_reg  <= 1'b0;
               byte_cnt_reg   <= '0;
`ifdef TB_UART_LB_PARITY_EN
               par_err_reg    <= 1'b0;
`endif
               wr_ptr_reg     <= '0;
               rd_ptr_reg     <= '0;
               empty_reg      <= 1'b1;
               overflow_reg   <= 1'b0;
               tx_state_reg   <= TX_IDLE;
               tx_cnt_reg     <= '0;
               tx_idx_reg     <= '0;
               tx_line_reg    <= 1'b1;
            end else begin
               sync1_reg      <= lb.uart_txd[gi];
               sync2_reg      <= sync1_reg;
               prev_reg       <= sync2_reg;
               rx_state_reg   <= rx_state_next;
               rx_cnt_reg     <= rx_cnt_next;
               rx_idx_reg     <= rx_idx_next;
               rx_shift_reg   <= rx_shift_next;
               rx_par_bad_reg <= rx_par_bad_next;
               rx_brk_reg     <= rx_brk_next;
               frame_err_reg  <= frame_err_next;
               byte_cnt_reg   <= byte_cnt_next;
`ifdef TB_UART_LB_PARITY_EN
               par_err_reg    <= par_err_next;
`endif
               wr_ptr_reg     <= wr_ptr_next;
               rd_ptr_reg     <= rd_ptr_next;
               empty_reg      <= empty_next;
               overflow_reg   <= overflow_next;
               tx_state_reg   <= tx_state_next;
               tx_cnt_reg     <= tx_cnt_next;
               tx_idx_reg     <= tx_idx_next;
               tx_line_reg    <= tx_line_next;
            end
         end

         // RX FSM: find start bit, sample mid-bit, judge stop (and parity)
         always_comb begin
            rx_state_next   = rx_state_reg;
            rx_cnt_next     = rx_cnt_reg + 1'b1;
            rx_idx_next     = rx_idx_reg;
            rx_shift_next   = rx_shift_reg;
            rx_par_bad_next = rx_par_bad_reg;
            rx_brk_next     = rx_brk_reg;
            frame_err_next  = frame_err_reg;
            byte_cnt_next   = byte_cnt_reg;
            rx_push_req     = 1'b0;
`ifdef TB_UART_LB_PARITY_EN
            par_err_next    = par_err_reg;
`endif
            case (rx_state_reg)
               RX_IDLE: begin
                  rx_cnt_next = '0;
                  rx_brk_next = 1'b0;
                  if (prev_reg && !sync2_reg) rx_state_next = RX_START;
               end
               RX_START: begin
                  if (rx_cnt_reg == HALF_LAST) begin
                     rx_cnt_next     = '0;
                     rx_idx_next     = '0;
                     rx_par_bad_next = 1'b0;
                     rx_state_next   = sync2_reg ? RX_IDLE : RX_DATA;
                  end
               end
               RX_DATA: begin
                  if (rx_cnt_reg == BIT_LAST) begin
                     rx_cnt_next   = '0;
                     rx_shift_next = {sync2_reg, rx_shift_reg[7:1]};
                     rx_idx_next   = rx_idx_reg + 3'd1;
                     if (rx_idx_reg == 3'd7) begin
`ifdef TB_UART_LB_PARITY_EN
                        rx_state_next = RX_PAR;
`else
                        rx_state_next = RX_STOP;
`endif
                     end
                  end
               end
               RX_PAR: begin
                  if (rx_cnt_reg == BIT_LAST) begin
                     rx_cnt_next     = '0;
                     rx_par_bad_next = sync2_reg ^ (^rx_shift_reg);
                     rx_state_next   = RX_STOP;
                  end
               end
               RX_STOP: begin
                  if (rx_brk_reg) begin
                     // Bad stop bit: hold here until the line idles high
                     rx_cnt_next = '0;
                     if (sync2_reg) rx_state_next = RX_IDLE;
                  end else if (rx_cnt_reg == BIT_LAST) begin
                     rx_cnt_next = '0;
                     if (!sync2_reg) begin
                        frame_err_next = 1'b1;
                        rx_brk_next    = 1'b1;
                     end else begin
                        rx_state_next = RX_IDLE;
                        if (!rx_par_bad_reg) begin
                           if (byte_cnt_reg != 16'hFFFF) byte_cnt_next = byte_cnt_reg + 16'd1;
                           rx_push_req = lb.loop_en[gi];
                        end
                     end
`ifdef TB_UART_LB_PARITY_EN
                     if (rx_par_bad_reg) par_err_next = 1'b1;
`endif
                  end
               end
               default: rx_state_next = RX_IDLE;
            endcase
         end

         // TX FSM and FIFO bookkeeping; the pop is issued on entry to START
         always_comb begin
            tx_state_next = tx_state_reg;
            tx_cnt_next   = tx_cnt_reg + 1'b1;
            tx_idx_next   = tx_idx_reg;
            tx_line_next  = tx_line_reg;
            tx_pop        = 1'b0;
            case (tx_state_reg)
               TX_IDLE: begin
                  tx_cnt_next  = '0;
                  tx_line_next = 1'b1;
                  if (!empty_reg && !lb.tx_hold[gi]) begin
                     tx_pop        = 1'b1;
                     tx_state_next = TX_START;
                     tx_line_next  = 1'b0;
                  end
               end
               TX_START: begin
                  if (tx_cnt_reg == BIT_LAST) begin
                     tx_cnt_next   = '0;
                     tx_idx_next   = '0;
                     tx_line_next  = rd_data_reg[0];
                     tx_state_next = TX_DATA;
                  end
               end
               TX_DATA: begin
                  if (tx_cnt_reg == BIT_LAST) begin
                     tx_cnt_next = '0;
                     if (tx_idx_reg == 3'd7) begin
`ifdef TB_UART_LB_PARITY_EN
                        tx_line_next  = ^rd_data_reg;
                        tx_state_next = TX_PAR;
`else
                        tx_line_next  = 1'b1;
                        tx_state_next = TX_STOP;
`endif
                     end else begin
                        tx_idx_next  = tx_idx_reg + 3'd1;
                        tx_line_next = rd_data_reg[tx_idx_reg + 3'd1];
                     end
                  end
               end
               TX_PAR: begin
                  if (tx_cnt_reg == BIT_LAST) begin
                     tx_cnt_next   = '0;
                     tx_line_next  = 1'b1;
                     tx_state_next = TX_STOP;
                  end
               end
               TX_STOP: begin
                  if (tx_cnt_reg == BIT_LAST) begin
                     tx_cnt_next = '0;
                     // Chain straight into the next frame when data is waiting
                     if (!empty_reg && !lb.tx_hold[gi]) begin
                        tx_pop        = 1'b1;
                        tx_line_next  = 1'b0;
                        tx_state_next = TX_START;
                     end else begin
                        tx_line_next  = 1'b1;
                        tx_state_next = TX_IDLE;
                     end
                  end
               end
               default: tx_state_next = TX_IDLE;
            endcase

            fifo_full     = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                            (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
            push_ok       = rx_push_req && (!fifo_full || tx_pop);
            overflow_next = overflow_reg || (rx_push_req && !push_ok);
            wr_ptr_next   = wr_ptr_reg + {{AW{1'b0}}, push_ok};
            rd_ptr_next   = rd_ptr_reg + {{AW{1'b0}}, tx_pop};
            empty_next    = (wr_ptr_next == rd_ptr_next);
         end

         // FIFO storage: write port
         always_ff @(posedge clk) begin
            if (push_ok) fifo_mem[wr_ptr_reg[AW-1:0]] <= rx_shift_reg;
         end

         // FIFO storage: registered read, loaded by the pop
         always_ff @(posedge clk) begin
            if (tx_pop) rd_data_reg <= fifo_mem[rd_ptr_reg[AW-1:0]];
         end
      end
   endgenerate
endmodule
